// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU controller and its RV32M sequencer:
// ALUOp groups, base ALU operation codes, Funct7 patterns, M-op and FSM enums.
package alu_ctrl_pkg;
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RI     = 2'b10;
  localparam logic [1:0] ALUOP_JL     = 2'b11;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
  localparam logic [3:0] OP_PASSB = 4'b1100;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} md_state_e;
endpackage

// File: rtl/md_iter_unit.sv
// Iterative RV32M datapath: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with sign fix-up and divide-by-zero/overflow shortcuts.
module md_iter_unit
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            special,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN);

  logic            r_busy, r_neg_p, r_neg_r;
  logic [CNT_W-1:0] r_cnt;
  md_op_e          r_op;
  logic [XLEN-1:0] r_hi, r_lo, r_opnd, r_result;

  logic            w_sa, w_sb, w_div_zero, w_ovf, w_ge;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_res;
  logic [XLEN:0]   w_sum, w_shift, w_trial;
  logic [XLEN-1:0] w_hi_nx, w_lo_nx, w_quo, w_rem, w_final;
  logic [2*XLEN-1:0] w_prod;

  assign w_sa = a[XLEN-1] && (op == MD_MULH || op == MD_MULHSU || op == MD_DIV || op == MD_REM);
  assign w_sb = b[XLEN-1] && (op == MD_MULH || op == MD_DIV || op == MD_REM);
  assign w_mag_a = w_sa ? -a : a;
  assign w_mag_b = w_sb ? -b : b;

  assign w_div_zero = op[2] && (b == '0);
  assign w_ovf = (op == MD_DIV || op == MD_REM) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign special = w_div_zero || w_ovf;
  // op[1] separates the remainder ops from the quotient ops inside the divide group
  assign w_special_res = w_div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  // Divide: hi holds the partial remainder, lo shifts dividend out and quotient in.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_opnd};
  assign w_ge = !w_trial[XLEN];

  assign w_hi_nx = r_op[2] ? (w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0]) : w_sum[XLEN:1];
  assign w_lo_nx = r_op[2] ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};

  assign w_prod = r_neg_p ? -{w_hi_nx, w_lo_nx} : {w_hi_nx, w_lo_nx};
  assign w_quo  = r_neg_p ? -w_lo_nx : w_lo_nx;
  assign w_rem  = r_neg_r ? -w_hi_nx : w_hi_nx;

  always_comb begin
    w_final = w_prod[2*XLEN-1:XLEN];
    case (r_op)
      MD_MUL:           w_final = w_prod[XLEN-1:0];
      MD_DIV, MD_DIVU:  w_final = w_quo;
      MD_REM, MD_REMU:  w_final = w_rem;
      default:          w_final = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  assign done   = r_busy && (r_cnt == CNT_W'(XLEN-1));
  assign busy   = r_busy;
  assign result = r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_op     <= MD_MUL;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
    end else if (abort) begin
      r_busy <= 1'b0;
    end else if (start) begin
      r_cnt   <= '0;
      r_op    <= op;
      r_neg_p <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      r_hi    <= '0;
      r_lo    <= op[2] ? w_mag_a : w_mag_b;
      r_opnd  <= op[2] ? w_mag_b : w_mag_a;
      r_busy  <= !special;
      if (special) r_result <= w_special_res;
    end else if (r_busy) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + 1'b1;
      if (done) begin
        r_busy   <= 1'b0;
        r_result <= w_final;
      end
    end
  end
endmodule

// File: rtl/alu_md_controller.sv
// EX-stage ALU controller: base ALU op decode plus an RV32M sequencer that
// stalls the pipeline while the iterative multiply/divide unit runs.
module alu_md_controller
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OP_W  = 4,
  parameter bit MD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            RType_i,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush_i,
  output logic [OP_W-1:0] Operation,
  output logic            md_sel,
  output logic            stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_valid
);
  md_state_e   r_state, w_state_next;
  logic [3:0]  w_op;
  logic        w_md_req, w_start, w_special, w_busy, w_done;

  always_comb begin
    w_op = OP_ADD;
    case (ALUOp)
      ALUOP_MEM: w_op = OP_ADD;
      ALUOP_JL:  w_op = OP_PASSB;
      ALUOP_BRANCH: begin
        case (Funct3)
          3'b000, 3'b001: w_op = OP_SUB;
          3'b100, 3'b101: w_op = OP_SLT;
          3'b110, 3'b111: w_op = OP_SLTU;
          default:        w_op = OP_ADD;
        endcase
      end
      default: begin
        case (Funct3)
          // I-type immediates can carry 0100000 in the Funct7 field; only R-type subtracts
          3'b000:  w_op = (RType_i && Funct7 == FUNCT7_ALT) ? OP_SUB : OP_ADD;
          3'b001:  w_op = OP_SLL;
          3'b010:  w_op = OP_SLT;
          3'b011:  w_op = OP_SLTU;
          3'b100:  w_op = OP_XOR;
          3'b101:  w_op = (Funct7 == FUNCT7_ALT) ? OP_SRA : OP_SRL;
          3'b110:  w_op = OP_OR;
          default: w_op = OP_AND;
        endcase
      end
    endcase
  end

  assign Operation = OP_W'(w_op);
  assign w_md_req  = MD_EN && valid_i && (ALUOp == ALUOP_RI) && RType_i && (Funct7 == FUNCT7_MULDIV);

  md_iter_unit #(.XLEN(XLEN)) u_md (
    .clk     (clk),
    .reset   (reset),
    .start   (w_start),
    .abort   (flush_i),
    .op      (md_op_e'(Funct3)),
    .a       (SrcA),
    .b       (SrcB),
    .special (w_special),
    .busy    (w_busy),
    .done    (w_done),
    .result  (md_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    if (flush_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_md_req) begin
          w_start      = 1'b1;
          w_state_next = w_special ? ST_DONE : ST_CALC;
        end
        ST_CALC: begin
          if (w_done)       w_state_next = ST_DONE;
          else if (!w_busy) w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // DONE still sees the same instruction, so md_req is deliberately ignored there
  assign stall    = ((r_state == ST_IDLE) && w_md_req) || (r_state == ST_CALC);
  assign md_valid = (r_state == ST_DONE) && !flush_i;
  assign md_sel   = md_valid;
endmodule
